fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 8, PC and instruction-memory address width.
REQ-002 Parameter INSTR_W, default 8, instruction width.
REQ-003 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-004 Single clock, active-low asynchronous reset: clk in, rst_n in; edge/polarity fixed as decided.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 branch_taken  in  1  branch-condition gate output (~zero & branch instruction).
REQ-008 branch_addr  in  ADDR_W  absolute branch target.
REQ-009 jump  in  1  unconditional jump request.
REQ-010 jump_addr  in  ADDR_W  absolute jump target.
REQ-011 halt  in  1  halt request from decode.
REQ-012 stall  in  1  downstream not ready; holds issued instruction.
REQ-013 imem_req  out  1  instruction-memory read request.
REQ-014 imem_addr  out  ADDR_W  read address, equals pc.
REQ-015 imem_ack  in  1  read data valid this cycle.
REQ-016 imem_rdata  in  INSTR_W  read data.
REQ-017 instr  out  INSTR_W  registered fetched instruction.
REQ-018 instr_valid  out  1  instr holds a valid instruction awaiting acceptance.
REQ-019 pc  out  ADDR_W  address of current/issued instruction.
REQ-020 halted  out  1  block in HALT state.

Function
REQ-021 FSM states SHALL be IDLE, FETCH, ISSUE, HALT.
REQ-022 IDLE SHALL transition unconditionally to FETCH on the next clock edge.
REQ-023 FETCH SHALL drive imem_req=1, imem_addr=pc, and hold until imem_ack=1.
REQ-024 On imem_ack in FETCH, instr SHALL capture imem_rdata and state SHALL go to ISSUE; instr_valid=1 from the following cycle (fetch latency: one cycle after ack).
REQ-025 ISSUE SHALL drive imem_req=0, instr_valid=1, and hold instr and pc stable while stall=1.
REQ-026 Acceptance SHALL be the ISSUE cycle with stall=0; branch_taken, jump, halt sampled only in that cycle, ignored otherwise.
REQ-027 On acceptance, next pc priority SHALL be: halt (pc unchanged, go HALT) > jump (jump_addr) > branch_taken (branch_addr) > pc+1; non-halt cases go FETCH.
REQ-028 pc+1 SHALL wrap modulo 2^ADDR_W (all-ones -> 0).
REQ-029 HALT SHALL hold halted=1, imem_req=0, instr_valid=0, pc frozen, until reset.
REQ-030 imem_ack outside FETCH SHALL be ignored.
REQ-031 instr_valid SHALL drop to 0 the cycle after acceptance.

Reset
REQ-032 On rst_n=0, asynchronously: state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, halted=0.
REQ-033 Reset asserted mid-FETCH or mid-ISSUE SHALL abort the transaction; no late imem_ack after release affects state unless in FETCH.

Structure
REQ-034 Shared package fetch_pkg SHALL hold the state enumeration and default ADDR_W/INSTR_W constants.
REQ-035 Next-PC selection SHALL be a sub-module pc_next (combinational priority mux plus incrementer).

Verification
REQ-036 Reset release, RESET_PC=0, ack 1 cycle after req, rdata=0x3A -> imem_addr=0, instr=0x3A, instr_valid=1, then pc=1 fetch.
REQ-037 ISSUE with stall=1 for 3 cycles, branch_taken=1 during stall then 0 at accept -> instr held, next pc=pc+1.
REQ-038 Accept with jump=1 jump_addr=0x40 and branch_taken=1 branch_addr=0x20 -> next imem_addr=0x40.
REQ-039 pc=0xFF, accept with no branch/jump -> next imem_addr=0x00.
REQ-040 Accept with halt=1 and jump=1 -> halted=1, pc unchanged, imem_req stays 0 for 10 cycles.
REQ-041 rst_n low while imem_req=1 awaiting ack -> imem_req=0 immediately, pc=RESET_PC, refetch after release.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding and
// default datapath widths.
package fetch_pkg;

    localparam int unsigned DEFAULT_ADDR_W  = 8;
    localparam int unsigned DEFAULT_INSTR_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_HALT  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_pc_next.sv
// Next-PC selection: priority mux (halt > jump > branch > sequential) plus a
// wrapping incrementer.
module pc_next
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              halt,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_addr,
    output logic [ADDR_W-1:0] pc_nxt
);

    logic [ADDR_W-1:0] pc_inc;

    // Carry out is dropped, so all-ones wraps to zero.
    assign pc_inc = pc + ADDR_W'(1);

    always_comb begin
        pc_nxt = pc_inc;
        if (halt) begin
            pc_nxt = pc;
        end else if (jump) begin
            pc_nxt = jump_addr;
        end else if (branch_taken) begin
            pc_nxt = branch_addr;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests one instruction at pc, issues it until the
// consumer accepts, then redirects pc according to halt/jump/branch.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned           ADDR_W   = DEFAULT_ADDR_W,
    parameter int unsigned           INSTR_W  = DEFAULT_INSTR_W,
    parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_addr,
    input  logic               jump,
    input  logic [ADDR_W-1:0]  jump_addr,
    input  logic               halt,
    input  logic               stall,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  pc,
    output logic               halted
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d, pc_sel;
    logic [INSTR_W-1:0] instr_q, instr_d;

    pc_next #(
        .ADDR_W (ADDR_W)
    ) u_pc_next (
        .pc           (pc_q),
        .halt         (halt),
        .jump         (jump),
        .jump_addr    (jump_addr),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .pc_nxt       (pc_sel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // Outputs decode from the state register only, so reset clears them at once.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                instr_valid = 1'b1;
                if (!stall) begin
                    pc_d    = pc_sel;
                    state_d = halt ? S_HALT : S_FETCH;
                end
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign instr     = instr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a vector table of accept-time redirects plus
// hand sequences for stall, halt and mid-fetch reset.
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       branch_taken;
    logic [7:0] branch_addr;
    logic       jump;
    logic [7:0] jump_addr;
    logic       halt;
    logic       stall;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_rdata;
    logic [7:0] instr;
    logic       instr_valid;
    logic [7:0] pc;
    logic       halted;

    logic [7:0]  mem [256];
    int unsigned ack_delay;
    int unsigned req_cnt;
    logic        spurious;
    int          checks = 0;
    int          errors = 0;

    fetch_unit #(
        .ADDR_W   (8),
        .INSTR_W  (8),
        .RESET_PC (8'h00)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .jump         (jump),
        .jump_addr    (jump_addr),
        .halt         (halt),
        .stall        (stall),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .pc           (pc),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    // Memory model: ack arrives ack_delay cycles after req rises; spurious
    // forces an ack with a poison value regardless of req.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) req_cnt <= 0;
        else        req_cnt <= imem_req ? req_cnt + 1 : 0;
    end
    assign imem_ack   = (imem_req && req_cnt == ack_delay) || spurious;
    assign imem_rdata = spurious ? 8'hEE : mem[imem_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_req(input string name, output logic [7:0] addr);
        int n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!imem_req) begin
            errors++;
            $display("FAIL %s: timeout waiting imem_req got 0 expected 1", name);
        end
        addr = imem_addr;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!instr_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!instr_valid) begin
            errors++;
            $display("FAIL %s: timeout waiting instr_valid got 0 expected 1", name);
        end
    endtask

    typedef struct {
        logic       bt;
        logic [7:0] ba;
        logic       jp;
        logic [7:0] ja;
        logic [7:0] cur_pc;
        logic [7:0] exp_pc;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic [7:0] a;

        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
        mem[0] = 8'h3A;

        //          bt    ba     jp    ja     cur    exp
        vecs[0] = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h01};
        vecs[1] = '{1'b1, 8'h20, 1'b0, 8'h00, 8'h01, 8'h20};
        vecs[2] = '{1'b1, 8'h20, 1'b1, 8'h40, 8'h20, 8'h40};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 8'hFF, 8'h40, 8'hFF};
        vecs[4] = '{1'b0, 8'h00, 1'b0, 8'h00, 8'hFF, 8'h00};
        vecs[5] = '{1'b1, 8'h10, 1'b0, 8'h00, 8'h00, 8'h10};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 8'h80, 8'h10, 8'h80};

        rst_n = 1'b0; stall = 1'b1; halt = 1'b0; jump = 1'b0; jump_addr = '0;
        branch_taken = 1'b0; branch_addr = '0; spurious = 1'b0; ack_delay = 1;

        #12;
        check("rst_req",    imem_req,    0);
        check("rst_valid",  instr_valid, 0);
        check("rst_halted", halted,      0);
        check("rst_pc",     pc,          0);
        check("rst_instr",  instr,       0);

        @(negedge clk);
        rst_n = 1'b1;
        wait_req("first_req", a);
        check("first_addr", a, 8'h00);

        for (int i = 0; i < 7; i++) begin
            wait_valid($sformatf("v%0d_valid", i));
            check($sformatf("v%0d_pc", i), pc, vecs[i].cur_pc);
            check($sformatf("v%0d_instr", i), instr, mem[vecs[i].cur_pc]);
            stall = 1'b0;
            branch_taken = vecs[i].bt; branch_addr = vecs[i].ba;
            jump = vecs[i].jp;         jump_addr = vecs[i].ja;
            @(negedge clk);
            stall = 1'b1; branch_taken = 1'b0; jump = 1'b0;
            check($sformatf("v%0d_drop", i), instr_valid, 0);
            wait_req($sformatf("v%0d_req", i), a);
            check($sformatf("v%0d_addr", i), a, vecs[i].exp_pc);
        end

        // Stall with branch asserted and a stray ack; neither may take effect.
        wait_valid("stall_valid");
        branch_taken = 1'b1; branch_addr = 8'h33; spurious = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_instr", instr, mem[8'h80]);
            check("stall_valid_hold", instr_valid, 1);
            check("stall_pc", pc, 8'h80);
        end
        spurious = 1'b0; branch_taken = 1'b0; stall = 1'b0;
        @(negedge clk);
        stall = 1'b1;
        wait_req("stall_req", a);
        check("stall_next_addr", a, 8'h81);

        // Halt beats jump; block then stays quiet.
        wait_valid("halt_valid");
        check("halt_instr", instr, mem[8'h81]);
        stall = 1'b0; halt = 1'b1; jump = 1'b1; jump_addr = 8'h40;
        @(negedge clk);
        stall = 1'b1; halt = 1'b0; jump = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("halt_halted", halted, 1);
            check("halt_req", imem_req, 0);
            check("halt_valid_low", instr_valid, 0);
            check("halt_pc", pc, 8'h81);
            @(negedge clk);
        end

        // Reset during an outstanding fetch.
        rst_n = 1'b0;
        #1;
        check("halt_rst_halted", halted, 0);
        @(negedge clk);
        ack_delay = 4;
        rst_n = 1'b1;
        wait_req("mid_req", a);
        check("mid_addr", a, 8'h00);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", imem_req, 0);
        check("mid_rst_pc", pc, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        ack_delay = 1;
        wait_req("refetch_req", a);
        check("refetch_addr", a, 8'h00);
        wait_valid("refetch_valid");
        check("refetch_instr", instr, 8'h3A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
